// File: rtl/regfile_wb_arbiter.sv
// ---------------------------------------------------------------------------
// regfile_wb_arbiter
//   Shares the single register-file write port (we3/a3/wd3) between the ALU
//   writeback path and the load writeback path. Each source feeds a small
//   skid FIFO through a valid/ready handshake; a round-robin arbiter drains
//   at most one entry per cycle into a registered write-port stage.
//
//   Writes to register 0 complete the handshake but are dropped at the FIFO
//   input, so the register file never sees a write to r0.
//
//   Optional build macro:
//     WB_CONFLICT_STATS_EN - enables the saturating 16-bit contention counter
//                            on conflict_cnt. When undefined the port is tied
//                            to zero and no counter logic exists.
// ---------------------------------------------------------------------------

// Per-source skid FIFO. Ready depends only on occupancy, never on valid.
module wb_skid_fifo #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_valid,
  output logic              push_ready,
  input  logic [ADDR_W-1:0] push_addr,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic              empty,
  output logic [ADDR_W-1:0] head_addr,
  output logic [DATA_W-1:0] head_data
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t            store [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              full;
  logic              enq;
  logic              deq;

  assign full       = (count == CNT_W'(DEPTH));
  assign empty      = (count == '0);
  assign push_ready = !full;

  // A completed handshake to r0 is swallowed here rather than queued.
  assign enq = push_valid && push_ready && (push_addr != '0);
  assign deq = pop && !empty;

  assign head_addr = store[rd_ptr].addr;
  assign head_data = store[rd_ptr].data;

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  // NOTE: all clocked state uses non-blocking (<=) so every register samples
  // the pre-edge values of its inputs, independent of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + 1'b1;
      if (deq) rd_ptr <= rd_ptr + 1'b1;
      case ({enq, deq})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage write.
  // NOTE: the storage array is deliberately not reset; occupancy alone marks
  // which slots are valid, so clearing the data would only cost reset fanout.
  always_ff @(posedge clk) begin
    if (enq) store[wr_ptr] <= '{addr: push_addr, data: push_data};
  end

endmodule

// Top level: two FIFOs, round-robin arbiter, registered write-port stage.
module regfile_wb_arbiter #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 5,
  parameter int FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [ADDR_W-1:0] alu_addr,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  output logic              we3,
  output logic [ADDR_W-1:0] a3,
  output logic [DATA_W-1:0] wd3,
  output logic              grant_src,
  output logic              busy,
  output logic [15:0]       conflict_cnt
);

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_MEM = 1'b1
  } src_e;

  logic              alu_empty;
  logic              mem_empty;
  logic [ADDR_W-1:0] alu_head_addr;
  logic [DATA_W-1:0] alu_head_data;
  logic [ADDR_W-1:0] mem_head_addr;
  logic [DATA_W-1:0] mem_head_data;

  logic              pop_alu;
  logic              pop_mem;
  logic              pop_any;
  logic              contention;
  src_e              sel_src;
  src_e              last_grant;
  src_e              last_grant_nxt;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;

  wb_skid_fifo #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_alu_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_valid (alu_valid),
    .push_ready (alu_ready),
    .push_addr  (alu_addr),
    .push_data  (alu_data),
    .pop        (pop_alu),
    .empty      (alu_empty),
    .head_addr  (alu_head_addr),
    .head_data  (alu_head_data)
  );

  wb_skid_fifo #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_mem_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_valid (mem_valid),
    .push_ready (mem_ready),
    .push_addr  (mem_addr),
    .push_data  (mem_data),
    .pop        (pop_mem),
    .empty      (mem_empty),
    .head_addr  (mem_head_addr),
    .head_data  (mem_head_data)
  );

  assign contention = !alu_empty && !mem_empty;
  assign pop_any    = pop_alu || pop_mem;

  // Round-robin pick; last_grant only moves when both sources compete.
  // NOTE: every output of this block is given a default first so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    pop_alu        = 1'b0;
    pop_mem        = 1'b0;
    sel_src        = SRC_ALU;
    last_grant_nxt = last_grant;
    if (contention) begin
      if (last_grant == SRC_MEM) begin
        pop_alu = 1'b1;
        sel_src = SRC_ALU;
      end else begin
        pop_mem = 1'b1;
        sel_src = SRC_MEM;
      end
      last_grant_nxt = sel_src;
    end else if (!alu_empty) begin
      pop_alu = 1'b1;
      sel_src = SRC_ALU;
    end else if (!mem_empty) begin
      pop_mem = 1'b1;
      sel_src = SRC_MEM;
    end
  end

  // Head of the granted FIFO.
  always_comb begin
    sel_addr = alu_head_addr;
    sel_data = alu_head_data;
    if (sel_src == SRC_MEM) begin
      sel_addr = mem_head_addr;
      sel_data = mem_head_data;
    end
  end

  // Registered write port; address/data/source hold while we3 is low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we3        <= 1'b0;
      a3         <= '0;
      wd3        <= '0;
      grant_src  <= 1'b0;
      last_grant <= SRC_MEM;
    end else begin
      we3        <= pop_any;
      last_grant <= last_grant_nxt;
      if (pop_any) begin
        a3        <= sel_addr;
        wd3       <= sel_data;
        grant_src <= sel_src;
      end
    end
  end

  assign busy = !alu_empty || !mem_empty || we3;

`ifdef WB_CONFLICT_STATS_EN
  logic [15:0] conflict_q;

  // Saturating count of cycles in which both FIFOs held entries.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      conflict_q <= '0;
    end else if (contention && (conflict_q != 16'hFFFF)) begin
      conflict_q <= conflict_q + 16'd1;
    end
  end

  assign conflict_cnt = conflict_q;
`else
  assign conflict_cnt = 16'd0;
`endif

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the single write port of the 32x32 register file (write enable, write address, write data) between two writeback requesters: the ALU result path and the load/memory result path.
- Each requester gets a small skid FIFO with a valid/ready handshake.
- A round-robin arbiter drains the FIFOs, at most one register write per cycle, through a registered write-port output stage.
- Sits between execute/memory stages and the register file.

Parameters:
- DATA_W, 32, register data width
- ADDR_W, 5, register address width
- FIFO_DEPTH, 2, entries per requester FIFO (power of two, >=2)

Ports:
- clk  input  1  clock; all state updates on posedge
- rst  input  1  asynchronous, active-high reset
- alu_valid  input  1  ALU writeback request
- alu_ready  output  1  ALU FIFO can accept
- alu_addr  input  ADDR_W  ALU destination register
- alu_data  input  DATA_W  ALU result
- mem_valid  input  1  load writeback request
- mem_ready  output  1  load FIFO can accept
- mem_addr  input  ADDR_W  load destination register
- mem_data  input  DATA_W  load data
- we3  output  1  register file write enable
- a3  output  ADDR_W  register file write address
- wd3  output  DATA_W  register file write data
- grant_src  output  1  source of current write: 0=ALU, 1=MEM
- busy  output  1  any FIFO non-empty or we3 asserted
- conflict_cnt  output  16  contention counter (see Optional Feature)

Behaviour:
- Reset (async, immediate on rst high):
  - Both FIFOs empty; alu_ready=mem_ready=1.
  - we3=0, a3=0, wd3=0, grant_src=0, busy=0, conflict_cnt=0.
  - last_grant=MEM, so ALU wins first contention.
- Reset mid-operation discards all queued entries; no partial write is issued.
- Handshake:
  - Transfer occurs when valid && ready at posedge.
  - ready = FIFO not full; it does not depend on valid, and there is no combinational path from valid to ready.
  - Push into a full FIFO is impossible, because ready is low while full.
  - Pop and push in the same cycle on a non-full FIFO are both honoured; count stays unchanged.
- Register zero: a transfer with addr==0 is accepted (handshake completes) but not enqueued, so no write is ever issued to register 0.
- Arbitration, each cycle:
  - Exactly one non-empty FIFO: pop its head.
  - Both non-empty: pop the source != last_grant, then update last_grant.
  - Both empty: no pop; we3 deasserts next cycle.
- Output stage is registered. A pop in cycle N gives we3=1 with a3/wd3/grant_src from the popped head in cycle N+1.
- When we3=0, a3/wd3/grant_src hold their last values.
- Latency: request accepted at edge N into an empty FIFO, uncontended, is popped in cycle N and appears on we3 in cycle N+1. The register file commits it at edge N+2.
- Sustained throughput is one write per cycle in aggregate. Under continuous contention each source gets 1 of every 2 cycles.
- Ordering:
  - Within a source, strict FIFO order.
  - Across sources, order follows arbitration only. Upstream hazard logic must not hold two in-flight writes to the same register from different sources.
- Counter widths: FIFO pointers are log2(FIFO_DEPTH) bits and wrap naturally. Occupancy counts are log2(FIFO_DEPTH)+1 bits.

Optional Feature:
- Macro: WB_CONFLICT_STATS_EN
- Defined: conflict_cnt increments by 1 on every cycle in which both FIFOs are non-empty; it saturates at 16'hFFFF and clears only on rst.
- Not defined: conflict_cnt is tied to 16'd0, no counter logic is synthesized, and the port list is unchanged.

Test Plan:
- Reset: assert rst asynchronously mid-cycle with both FIFOs holding 2 entries -> immediately we3=0, busy=0, both ready=1; after release, no writes issue.
- Single ALU write: alu addr=9 data=32'h20 accepted at edge N -> we3=1, a3=9, wd3=32'h20, grant_src=0 in cycle N+1 only.
- Simultaneous ALU/MEM: both push 2 entries at once (ALU r5=3, r6=4; MEM r7=5, r8=6) -> write order r5, r7, r6, r8 on consecutive cycles; grant_src 0,1,0,1.
- Backpressure: MEM pushes 3 back-to-back with output contended by ALU -> mem_ready=0 once 2 are queued; no entry lost; all 3 written in order.
- Register zero: ALU write addr=0 data=32'hDEAD -> handshake completes; we3 never asserts with a3=0.
- With WB_CONFLICT_STATS_EN defined: hold both FIFOs non-empty for 10 cycles -> conflict_cnt=10. Without the macro, the same stimulus gives conflict_cnt=0.
